// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - shared constants and FSM encoding for the sequential multiplier
package kgp_pkg;

    localparam int WIDTH  = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - launch/writeback signal bundle between control unit and multiplier
interface seq_multiplier_if #(
    parameter int WIDTH  = kgp_pkg::WIDTH,
    parameter int REG_AW = kgp_pkg::REG_AW
);

    logic              start;
    logic              is_signed;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [REG_AW-1:0] dest_reg;
    logic              flush;
    logic              busy;
    logic              wb_write;
    logic [REG_AW-1:0] wb_reg;
    logic [WIDTH-1:0]  wb_data;
    logic [WIDTH-1:0]  prod_hi;
    logic              start_err;

    modport master (
        output start, is_signed, op_a, op_b, dest_reg, flush,
        input  busy, wb_write, wb_reg, wb_data, prod_hi, start_err
    );

    modport slave (
        input  start, is_signed, op_a, op_b, dest_reg, flush,
        output busy, wb_write, wb_reg, wb_data, prod_hi, start_err
    );

endinterface

// File: rtl/mul_sign_fix.sv
// rtl/mul_sign_fix.sv - conditional two's-complement negate (abs at launch, sign restore at completion)
module mul_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] din,
    input  logic         neg,
    output logic [N-1:0] dout
);

    // The most negative value maps to itself, which is its correct unsigned magnitude.
    assign dout = neg ? (~din + N'(1)) : din;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 shift-add multiplier with one-cycle register-file writeback
module seq_multiplier #(
    parameter int WIDTH  = kgp_pkg::WIDTH,
    parameter int REG_AW = kgp_pkg::REG_AW
) (
    input  logic             clk,
    input  logic             rst,
    seq_multiplier_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    kgp_pkg::state_t     state_q, state_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic [REG_AW-1:0]   dest_q, dest_d;
    logic [REG_AW-1:0]   wb_reg_q, wb_reg_d;
    logic [WIDTH-1:0]    wb_data_q, wb_data_d;
    logic [WIDTH-1:0]    prod_hi_q, prod_hi_d;
    logic                start_err_q, start_err_d;

    logic [WIDTH-1:0]    abs_a, abs_b;
    logic [2*WIDTH-1:0]  result;
    logic [WIDTH:0]      sum;

    mul_sign_fix #(.N(WIDTH)) u_abs_a (
        .din  (bus.op_a),
        .neg  (bus.is_signed & bus.op_a[WIDTH-1]),
        .dout (abs_a)
    );

    mul_sign_fix #(.N(WIDTH)) u_abs_b (
        .din  (bus.op_b),
        .neg  (bus.is_signed & bus.op_b[WIDTH-1]),
        .dout (abs_b)
    );

    mul_sign_fix #(.N(2*WIDTH)) u_result (
        .din  (acc_q),
        .neg  (neg_q),
        .dout (result)
    );

    always_comb begin
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        dest_d      = dest_q;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        prod_hi_d   = prod_hi_q;
        start_err_d = bus.start & (state_q == kgp_pkg::RUN);

        // DONE also accepts a launch so back-to-back ops need no idle bubble.
        if ((state_q == kgp_pkg::IDLE || state_q == kgp_pkg::DONE) && bus.start && !bus.flush) begin
            mcand_d  = abs_a;
            mplier_d = abs_b;
            dest_d   = bus.dest_reg;
            neg_d    = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = kgp_pkg::RUN;
        end else if (state_q == kgp_pkg::DONE || bus.flush) begin
            state_d = kgp_pkg::IDLE;
        end else if (state_q == kgp_pkg::RUN) begin
            if (cnt_q == CW'(WIDTH)) begin
                wb_data_d = result[WIDTH-1:0];
                prod_hi_d = result[2*WIDTH-1:WIDTH];
                wb_reg_d  = dest_q;
                state_d   = kgp_pkg::DONE;
            end else begin
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= kgp_pkg::IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            dest_q      <= '0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            prod_hi_q   <= '0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            dest_q      <= dest_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            prod_hi_q   <= prod_hi_d;
            start_err_q <= start_err_d;
        end
    end

    assign bus.busy      = (state_q != kgp_pkg::IDLE);
    assign bus.wb_write  = (state_q == kgp_pkg::DONE) & ~bus.flush;
    assign bus.wb_reg    = wb_reg_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.prod_hi   = prod_hi_q;
    assign bus.start_err = start_err_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_multiplier_if bus ();

    seq_multiplier dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  r;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int launch_cyc = 0;
    int wb_count = 0;
    int err_count = 0;
    int wb0, err0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.start_err) err_count++;
        if (rst_n && bus.wb_write) begin
            wb_count++;
            if (sb.size() == 0) begin
                chk("unexpected_wb", 64'(bus.wb_data), 64'hDEAD_0000_0000_0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_reg", 64'(bus.wb_reg), 64'(e.r));
                chk("wb_data", 64'(bus.wb_data), 64'(e.lo));
                chk("prod_hi", 64'(bus.prod_hi), 64'(e.hi));
                chk("latency", 64'(cyc - launch_cyc), 64'd33);
            end
        end
    end

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d);
        bus.is_signed = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.dest_reg  = d;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        launch_cyc = cyc;
        bus.start  = 1'b0;
    endtask

    task automatic wait_wb(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wb_write && n < budget);
        chk("wb_seen", 64'(bus.wb_write), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < budget);
        chk("idle_reached", 64'(bus.busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      64'(bus.busy), 64'd0);
        chk({tag, "_wb_write"},  64'(bus.wb_write), 64'd0);
        chk({tag, "_wb_reg"},    64'(bus.wb_reg), 64'd0);
        chk({tag, "_wb_data"},   64'(bus.wb_data), 64'd0);
        chk({tag, "_prod_hi"},   64'(bus.prod_hi), 64'd0);
        chk({tag, "_start_err"}, 64'(bus.start_err), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.flush = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.dest_reg = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // unsigned basic and signed negative
        sb.push_back('{5'd10, 32'h0000_002A, 32'h0000_0000});
        launch(1'b0, 32'd7, 32'd6, 5'd10);
        wait_wb(40);
        wait_idle(10);
        sb.push_back('{5'd3, 32'hFFFF_FFF1, 32'hFFFF_FFFF});
        launch(1'b1, 32'hFFFF_FFFD, 32'd5, 5'd3);
        wait_wb(40);
        wait_idle(10);

        // extremes, second launch sampled on the DONE edge
        wb0 = wb_count;
        sb.push_back('{5'd31, 32'h0000_0001, 32'hFFFF_FFFE});
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        wait_wb(40);
        sb.push_back('{5'd1, 32'h0000_0000, 32'h4000_0000});
        launch(1'b1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        wait_wb(40);
        wait_idle(10);
        chk("b2b_wb_count", 64'(wb_count - wb0), 64'd2);

        // start while busy: ignored, one error pulse
        wb0 = wb_count; err0 = err_count;
        sb.push_back('{5'd5, 32'h0000_0000, 32'h0000_0003});
        launch(1'b0, 32'h0001_0000, 32'h0003_0000, 5'd5);
        repeat (4) @(posedge clk);
        #1;
        bus.op_a = 32'd9; bus.dest_reg = 5'd6; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_wb(40);
        wait_idle(10);
        chk("start_err_pulses", 64'(err_count - err0), 64'd1);
        chk("busy_start_wb_count", 64'(wb_count - wb0), 64'd1);

        // flush mid-run, then start+flush in IDLE, then a fresh op
        wb0 = wb_count;
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        repeat (40) @(negedge clk);
        chk("start_flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_no_wb", 64'(wb_count - wb0), 64'd0);
        chk("flush_prod_hi_held", 64'(bus.prod_hi), 64'd3);
        sb.push_back('{5'd9, 32'h0000_0090, 32'h0000_0000});
        launch(1'b0, 32'd12, 32'd12, 5'd9);
        wait_wb(40);
        wait_idle(10);

        // asynchronous reset mid-run
        wb0 = wb_count;
        launch(1'b0, 32'd5, 32'd5, 5'd4);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_no_wb", 64'(wb_count - wb0), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
